// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
//   Word-organised data memory for the LSU/MEM stage. It takes one request at a
//   time over a valid/ready handshake and returns one response over a second
//   valid/ready handshake. It supports RV32 sub-word loads and stores
//   (LB/LH/LW/LBU/LHU, SB/SH/SW). The response appears LATENCY cycles after the
//   request is accepted. Misaligned accesses, out-of-range accesses and illegal
//   sizes are reported as faults. After reset, an optional hardware sweep
//   zeroes the whole array.
//
// Parameters
//   MEM_DEPTH       number of 32-bit words (word index = req_addr >> 2)
//   LATENCY         cycles from request accept to resp_valid, >= 1
//   CLEAR_ON_RESET  1: zero every word after reset, 0: skip the sweep
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   init_done    out  high once the post-reset sweep has finished
//   req_valid    in   request present
//   req_ready    out  a request is accepted this cycle
//   req_write    in   1 = store, 0 = load
//   req_addr     in   byte address
//   req_size     in   funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_wdata    in   store data, right-aligned
//   resp_valid   out  response present, held until resp_ready
//   resp_ready   in   consumer takes the response
//   resp_rdata   out  extended load data; 0 for stores and faults
//   resp_fault   out  request was misaligned, out of range or illegal size
// -----------------------------------------------------------------------------
module data_memory_ctrl #(
  parameter int MEM_DEPTH      = 16384,
  parameter int LATENCY        = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        init_done,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_DEPTH - 1);
  // WAIT lasts LATENCY-1 cycles; the counter runs 0..LATENCY-2.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_sweep_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_init_done;

  // Attributes of the accepted request, held until the response completes.
  logic               r_fault;
  logic               r_is_load;
  logic [2:0]         r_size;
  logic [1:0]         r_off;
  logic [31:0]        r_rd_word;

  logic [31:0]        r_mem [MEM_DEPTH];

  logic               w_accept;
  logic               w_fault;
  logic               w_out_of_range;
  logic [31:0]        w_word_idx;
  logic [IDX_W-1:0]   w_mem_idx;
  logic [31:0]        w_wdata_lanes;
  logic [3:0]         w_req_be;
  logic               w_sweep_we;
  logic               w_store_we;
  logic               w_we;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [3:0]         w_wr_be;
  logic [31:0]        w_wr_data;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign w_accept       = (r_state == S_IDLE) && req_valid;
  assign w_word_idx     = {2'b00, req_addr[31:2]};
  assign w_out_of_range = (w_word_idx >= 32'(MEM_DEPTH));
  assign w_mem_idx      = req_addr[IDX_W+1:2];

  always_comb begin
    w_fault = 1'b0;
    case (req_size)
      3'b000:  w_fault = 1'b0;
      3'b001:  w_fault = req_addr[0];
      3'b010:  w_fault = |req_addr[1:0];
      3'b100:  w_fault = req_write;
      3'b101:  w_fault = req_write | req_addr[0];
      default: w_fault = 1'b1;
    endcase
    if (w_out_of_range) begin
      w_fault = 1'b1;
    end
  end

  // Store data is replicated across lanes so that each byte enable picks up
  // the right bits, whatever the offset.
  always_comb begin
    w_wdata_lanes = req_wdata;
    w_req_be      = 4'b1111;
    case (req_size[1:0])
      2'b00: begin
        w_wdata_lanes = {4{req_wdata[7:0]}};
        w_req_be      = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        w_wdata_lanes = {2{req_wdata[15:0]}};
        w_req_be      = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata_lanes = req_wdata;
        w_req_be      = 4'b1111;
      end
    endcase
  end

  // The sweep write is gated by reset so the array stays untouched while
  // reset is held, even if the clock keeps running.
  assign w_sweep_we = (r_state == S_INIT) && CLEAR_ON_RESET && reset;
  assign w_store_we = w_accept && req_write && !w_fault;
  assign w_we       = w_sweep_we || w_store_we;
  assign w_wr_idx   = (r_state == S_INIT) ? r_sweep_idx : w_mem_idx;
  assign w_wr_be    = (r_state == S_INIT) ? 4'b1111 : w_req_be;
  assign w_wr_data  = (r_state == S_INIT) ? 32'h0 : w_wdata_lanes;

  // ---------------------------------------------------------------------------
  // Backing array: byte-enable write, registered read. A store and a load
  // never coincide, so read-before-write ordering does not matter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wr_be[b]) begin
          r_mem[w_wr_idx][b*8 +: 8] <= w_wr_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rd_word <= r_mem[w_mem_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_INIT;
      r_sweep_idx <= '0;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_fault     <= 1'b0;
      r_is_load   <= 1'b0;
      r_size      <= 3'b000;
      r_off       <= 2'b00;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_INIT) begin
        r_sweep_idx <= r_sweep_idx + 1'b1;
        if (w_state_next == S_IDLE) begin
          r_init_done <= 1'b1;
        end
      end
      if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (w_accept) begin
        r_fault   <= w_fault;
        r_is_load <= !req_write;
        r_size    <= req_size;
        r_off     <= req_addr[1:0];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      S_INIT: begin
        if (!CLEAR_ON_RESET || (r_sweep_idx == LAST_IDX)) begin
          w_state_next = S_IDLE;
        end
      end
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == LAST_CNT) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_INIT;
    endcase
  end

  assign init_done = r_init_done;

  // ---------------------------------------------------------------------------
  // Load data extraction and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    w_byte = r_rd_word[7:0];
    case (r_off)
      2'd0:    w_byte = r_rd_word[7:0];
      2'd1:    w_byte = r_rd_word[15:8];
      2'd2:    w_byte = r_rd_word[23:16];
      default: w_byte = r_rd_word[31:24];
    endcase
  end

  assign w_half = r_off[1] ? r_rd_word[31:16] : r_rd_word[15:0];

  // Outputs are forced to zero outside RESP, so reset clears them at once
  // even though the read register itself has no reset.
  always_comb begin
    resp_rdata = 32'h0;
    resp_fault = 1'b0;
    if (r_state == S_RESP) begin
      resp_fault = r_fault;
      if (r_is_load && !r_fault) begin
        case (r_size[1:0])
          2'b00:   resp_rdata = r_size[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
          2'b01:   resp_rdata = r_size[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
          default: resp_rdata = r_rd_word;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_memory_ctrl
//   Two instances share the clock and request bus: dut_a (LATENCY=1) and
//   dut_b (LATENCY=3), both MEM_DEPTH=16 with the clear sweep enabled. The
//   signal sel routes the handshakes and outputs to one instance at a time.
// -----------------------------------------------------------------------------
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        resp_ready;

  logic init_done_a, req_ready_a, resp_valid_a, resp_fault_a;
  logic init_done_b, req_ready_b, resp_valid_b, resp_fault_b;
  logic [31:0] resp_rdata_a, resp_rdata_b;
  logic req_valid_a, req_valid_b, resp_ready_a, resp_ready_b;

  logic        init_done, req_ready, resp_valid, resp_fault;
  logic [31:0] resp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign req_valid_a  = req_valid  & ~sel;
  assign req_valid_b  = req_valid  &  sel;
  assign resp_ready_a = resp_ready & ~sel;
  assign resp_ready_b = resp_ready &  sel;
  assign init_done    = sel ? init_done_b  : init_done_a;
  assign req_ready    = sel ? req_ready_b  : req_ready_a;
  assign resp_valid   = sel ? resp_valid_b : resp_valid_a;
  assign resp_rdata   = sel ? resp_rdata_b : resp_rdata_a;
  assign resp_fault   = sel ? resp_fault_b : resp_fault_a;

  data_memory_ctrl #(.MEM_DEPTH(16), .LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .reset(reset), .init_done(init_done_a),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
    .resp_rdata(resp_rdata_a), .resp_fault(resp_fault_a)
  );

  data_memory_ctrl #(.MEM_DEPTH(16), .LATENCY(3), .CLEAR_ON_RESET(1'b1)) dut_b (
    .clk(clk), .reset(reset), .init_done(init_done_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
    .resp_rdata(resp_rdata_b), .resp_fault(resp_fault_b)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  localparam int NVEC = 29;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Entered and left on a negedge. Returns the response and the number of
  // cycles from accept to resp_valid (-1 on timeout).
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rd,
                        output logic flt, output int lat);
    int n;
    rd  = 32'h0;
    flt = 1'b0;
    lat = -1;
    n   = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", {31'h0, req_ready}, 32'h1);
      return;
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      check("resp_valid_timeout", {31'h0, resp_valid}, 32'h1);
      lat = -1;
      return;
    end
    rd  = resp_rdata;
    flt = resp_fault;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    $display("[TB] dut_%s %s addr=0x%08h size=%03b wdata=0x%08h -> rdata=0x%08h fault=%0b lat=%0d",
             sel ? "b" : "a", wr ? "ST" : "LD", addr, size, wdata, rd, flt, lat);
  endtask

  // Counts cycles from reset release (caller releases on a negedge) to
  // init_done, and counts any cycle where a response or ready shows up early.
  task automatic wait_init(output int n, output int early);
    n = 0;
    early = 0;
    while (!init_done && n < 200) begin
      @(negedge clk);
      n++;
      if (resp_valid_a || resp_valid_b) early++;
      if (!init_done && (req_ready_a || req_ready_b)) early++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        flt;
    int          lat;
    int          n;
    int          early;

    vecs[0]  = '{1'b0, 32'h3C, 3'b010, 32'h0,        32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 32'h10, 3'b010, 32'h8899AABB, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, 32'h10, 3'b000, 32'h0,        32'hFFFFFFBB, 1'b0};
    vecs[3]  = '{1'b0, 32'h13, 3'b100, 32'h0,        32'h00000088, 1'b0};
    vecs[4]  = '{1'b0, 32'h12, 3'b001, 32'h0,        32'hFFFF8899, 1'b0};
    vecs[5]  = '{1'b0, 32'h10, 3'b101, 32'h0,        32'h0000AABB, 1'b0};
    vecs[6]  = '{1'b1, 32'h11, 3'b000, 32'hFFFFFF5A, 32'h00000000, 1'b0};
    vecs[7]  = '{1'b0, 32'h10, 3'b010, 32'h0,        32'h88995ABB, 1'b0};
    vecs[8]  = '{1'b1, 32'h12, 3'b001, 32'hABCD1234, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b0, 32'h10, 3'b010, 32'h0,        32'h12345ABB, 1'b0};
    vecs[10] = '{1'b0, 32'h11, 3'b000, 32'h0,        32'h0000005A, 1'b0};
    vecs[11] = '{1'b0, 32'h10, 3'b001, 32'h0,        32'h00005ABB, 1'b0};
    vecs[12] = '{1'b1, 32'h04, 3'b010, 32'hCAFEF00D, 32'h00000000, 1'b0};
    vecs[13] = '{1'b0, 32'h06, 3'b010, 32'h0,        32'h00000000, 1'b1};
    vecs[14] = '{1'b0, 32'h05, 3'b001, 32'h0,        32'h00000000, 1'b1};
    vecs[15] = '{1'b1, 32'h04, 3'b100, 32'h11111111, 32'h00000000, 1'b1};
    vecs[16] = '{1'b1, 32'h05, 3'b001, 32'h22222222, 32'h00000000, 1'b1};
    vecs[17] = '{1'b0, 32'h04, 3'b010, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[18] = '{1'b0, 32'h40, 3'b010, 32'h0,        32'h00000000, 1'b1};
    vecs[19] = '{1'b1, 32'h40, 3'b010, 32'hDEADBEEF, 32'h00000000, 1'b1};
    vecs[20] = '{1'b0, 32'h00, 3'b010, 32'h0,        32'h00000000, 1'b0};
    vecs[21] = '{1'b0, 32'h04, 3'b011, 32'h0,        32'h00000000, 1'b1};
    vecs[22] = '{1'b0, 32'h04, 3'b110, 32'h0,        32'h00000000, 1'b1};
    vecs[23] = '{1'b0, 32'h07, 3'b000, 32'h0,        32'hFFFFFFCA, 1'b0};
    vecs[24] = '{1'b0, 32'h06, 3'b101, 32'h0,        32'h0000CAFE, 1'b0};
    vecs[25] = '{1'b1, 32'h3F, 3'b000, 32'h00000080, 32'h00000000, 1'b0};
    vecs[26] = '{1'b0, 32'h3F, 3'b000, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[27] = '{1'b0, 32'h3C, 3'b010, 32'h0,        32'h80000000, 1'b0};
    vecs[28] = '{1'b0, 32'h04, 3'b010, 32'h0,        32'hCAFEF00D, 1'b0};

    reset      = 1'b0;
    sel        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h0;
    req_size   = 3'b000;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;

    // Reset state and sweep length
    repeat (3) @(negedge clk);
    check("reset_init_done",  {31'h0, init_done},  32'h0);
    check("reset_req_ready",  {31'h0, req_ready},  32'h0);
    check("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("reset_resp_rdata", resp_rdata,          32'h0);
    check("reset_resp_fault", {31'h0, resp_fault}, 32'h0);
    reset = 1'b1;
    wait_init(n, early);
    $display("[TB] init after %0d cycles", n);
    check("init_cycles", 32'(n), 32'd16);
    check("init_no_early_activity", 32'(early), 32'd0);
    check("init_done_b", {31'h0, init_done_b}, 32'h1);

    // Table of single transactions on the LATENCY=1 instance
    for (int i = 0; i < NVEC; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, flt, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_fault", i), {31'h0, flt}, {31'h0, vecs[i].exp_fault});
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
    end

    // LATENCY=3: held response, stable data, back-to-back request
    sel = 1'b1;
    @(negedge clk);
    do_req(1'b1, 32'h20, 3'b010, 32'h13579BDF, rd, flt, lat);
    check("b_store_latency", 32'(lat), 32'd3);
    do_req(1'b0, 32'h06, 3'b010, 32'h0, rd, flt, lat);
    check("b_fault_flag", {31'h0, flt}, 32'h1);
    check("b_fault_rdata", rd, 32'h0);
    check("b_fault_latency", 32'(lat), 32'd3);

    check("b_ready_before", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h20;
    req_size  = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("b_wait%0d_ready", c), {31'h0, req_ready}, 32'h0);
      check($sformatf("b_wait%0d_valid", c), {31'h0, resp_valid}, (c == 3) ? 32'h1 : 32'h0);
      if (c < 3) @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("b_hold%0d_valid", k), {31'h0, resp_valid}, 32'h1);
      check($sformatf("b_hold%0d_rdata", k), resp_rdata, 32'h13579BDF);
      check($sformatf("b_hold%0d_fault", k), {31'h0, resp_fault}, 32'h0);
      check($sformatf("b_hold%0d_ready", k), {31'h0, req_ready}, 32'h0);
      @(negedge clk);
    end
    check("b_hold_end_valid", {31'h0, resp_valid}, 32'h1);
    $display("[TB] dut_b LD addr=0x00000020 held 5 cycles rdata=0x%08h", resp_rdata);
    // Take the response and present the next request in the same cycle.
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h22;
    req_size   = 3'b001;
    @(negedge clk);
    resp_ready = 1'b0;
    check("b2b_ready", {31'h0, req_ready}, 32'h1);
    check("b2b_valid_low", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_latency", 32'(lat), 32'd3);
    check("b2b_rdata", resp_rdata, 32'h00001357);
    $display("[TB] dut_b LH addr=0x00000022 back-to-back rdata=0x%08h lat=%0d", resp_rdata, lat);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Reset while a load waits
    do_req(1'b1, 32'h24, 3'b010, 32'hA5A5A5A5, rd, flt, lat);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h24;
    req_size  = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("rst_wait_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_wait_req_ready",  {31'h0, req_ready},  32'h0);
    check("rst_wait_init_done",  {31'h0, init_done},  32'h0);
    check("rst_wait_rdata",      resp_rdata,          32'h0);
    check("rst_wait_fault",      {31'h0, resp_fault}, 32'h0);
    $display("[TB] dut_b reset asserted during WAIT");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_init(n, early);
    check("reinit_cycles", 32'(n), 32'd16);
    check("reinit_no_early_activity", 32'(early), 32'd0);
    check("reinit_no_stale_resp", {31'h0, resp_valid}, 32'h0);
    do_req(1'b0, 32'h24, 3'b010, 32'h0, rd, flt, lat);
    check("reinit_b_cleared", rd, 32'h0);
    sel = 1'b0;
    do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, flt, lat);
    check("reinit_a_cleared", rd, 32'h0);
    check("reinit_a_latency", 32'(lat), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
